// File: rtl/decode_ctrl_pipe.sv
// ID-stage control decoder for RV32I (optional M extension) with an integrated ID/EX control
// register. instr_d is decoded combinationally and the control word plus register indices are
// registered into EX one cycle later. Illegal encodings raise a held trap request.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   instr_d, pc_d   instruction and its pc from the IF/ID register
//   valid_d         instr_d is real (0 = bubble)
//   stall_e         hold EX register contents
//   flush_e         load a bubble into the EX register
//   trap_ack        trap handler accepted trap_req
//   *_e             registered EX-stage control and register indices
//   trap_req        illegal-instruction trap pending (held until trap_ack)
//   trap_pc         pc of the offending instruction
module decode_ctrl_pipe #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALU_CTRL_W = 4,
   parameter int unsigned ENABLE_M   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_d,
   input  logic [XLEN-1:0]       pc_d,
   input  logic                  valid_d,
   input  logic                  stall_e,
   input  logic                  flush_e,
   input  logic                  trap_ack,
   output logic                  valid_e,
   output logic                  reg_write_e,
   output logic [1:0]            res_src_e,
   output logic                  mem_write_e,
   output logic                  jump_e,
   output logic                  branch_e,
   output logic [2:0]            funct3_e,
   output logic [ALU_CTRL_W-1:0] alu_control_e,
   output logic [1:0]            alu_src_e,
   output logic [2:0]            imm_src_e,
   output logic [4:0]            rd_e,
   output logic [4:0]            rs1_e,
   output logic [4:0]            rs2_e,
   output logic                  trap_req,
   output logic [XLEN-1:0]       trap_pc
);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpOp     = 7'b0110011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [3:0] AluAdd   = 4'd0;
   localparam logic [3:0] AluSub   = 4'd1;
   localparam logic [3:0] AluAnd   = 4'd2;
   localparam logic [3:0] AluOr    = 4'd3;
   localparam logic [3:0] AluXor   = 4'd4;
   localparam logic [3:0] AluSlt   = 4'd5;
   localparam logic [3:0] AluSltu  = 4'd6;
   localparam logic [3:0] AluSll   = 4'd7;
   localparam logic [3:0] AluSrl   = 4'd8;
   localparam logic [3:0] AluSra   = 4'd9;
   localparam logic [3:0] AluPassB = 4'd10;

   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   localparam logic [6:0] F7Zero = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;
   localparam logic [6:0] F7Mul  = 7'b0000001;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic [1:0] res_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] funct3;
      logic [3:0] alu;
      logic [1:0] alu_src;
      logic [2:0] imm_src;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ex_ctrl_t;

   typedef enum logic [0:0] {StRun, StTrap} state_e;

   state_e         r_state;
   state_e         w_state_d;
   ex_ctrl_t       r_ex;
   ex_ctrl_t       w_ex_d;
   ex_ctrl_t       w_dec;
   logic           w_illegal;
   logic           r_trap_req;
   logic           w_trap_req_d;
   logic [XLEN-1:0] r_trap_pc;
   logic [XLEN-1:0] w_trap_pc_d;
   logic           w_trap_hold;
   logic           w_take_trap;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign w_opcode = instr_d[6:0];
   assign w_funct3 = instr_d[14:12];
   assign w_funct7 = instr_d[31:25];

   // funct3 -> ALU op; alt selects SUB for 000 and SRA for 101
   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? AluSub : AluAdd;
         3'b001:  op = AluSll;
         3'b010:  op = AluSlt;
         3'b011:  op = AluSltu;
         3'b100:  op = AluXor;
         3'b101:  op = alt ? AluSra : AluSrl;
         3'b110:  op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   // Combinational decode. Opcode matches include instr[1:0]=11, so compressed-looking
   // words fall through to the illegal default.
   always_comb begin
      w_dec        = '0;
      w_illegal    = 1'b0;
      w_dec.valid  = 1'b1;
      w_dec.funct3 = w_funct3;
      w_dec.rd     = instr_d[11:7];
      w_dec.rs1    = instr_d[19:15];
      w_dec.rs2    = instr_d[24:20];
      case (w_opcode)
         OpLoad: begin
            w_dec.reg_write = 1'b1;
            w_dec.res_src   = 2'b01;
            w_dec.alu_src   = 2'b01;
            w_dec.imm_src   = ImmI;
            w_dec.alu       = AluAdd;
            if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
               w_illegal = 1'b1;
            end
         end
         OpImm: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 2'b01;
            w_dec.imm_src   = ImmI;
            // Only right shifts have an alternate form (srai); addi has no sub.
            w_dec.alu       = alu_of(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
            if (w_funct3 == 3'b001 && w_funct7 != F7Zero) begin
               w_illegal = 1'b1;
            end
            if (w_funct3 == 3'b101 && w_funct7 != F7Zero && w_funct7 != F7Alt) begin
               w_illegal = 1'b1;
            end
         end
         OpAuipc: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 2'b11;
            w_dec.imm_src   = ImmU;
            w_dec.alu       = AluAdd;
         end
         OpStore: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 2'b01;
            w_dec.imm_src   = ImmS;
            w_dec.alu       = AluAdd;
            if (w_funct3 > 3'b010) begin
               w_illegal = 1'b1;
            end
         end
         OpOp: begin
            if (w_funct7 == F7Mul) begin
               if (ENABLE_M != 0) begin
                  w_dec.reg_write = 1'b1;
                  w_dec.res_src   = 2'b11;
               end else begin
                  w_illegal = 1'b1;
               end
            end else if (w_funct7 == F7Zero ||
                         (w_funct7 == F7Alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
               w_dec.reg_write = 1'b1;
               w_dec.alu       = alu_of(w_funct3, w_funct7[5]);
            end else begin
               w_illegal = 1'b1;
            end
         end
         OpLui: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 2'b01;
            w_dec.imm_src   = ImmU;
            w_dec.alu       = AluPassB;
         end
         OpBranch: begin
            w_dec.branch  = 1'b1;
            w_dec.imm_src = ImmB;
            case (w_funct3)
               3'b000, 3'b001: w_dec.alu = AluSub;
               3'b100, 3'b101: w_dec.alu = AluSlt;
               3'b110, 3'b111: w_dec.alu = AluSltu;
               default:        w_illegal = 1'b1;
            endcase
         end
         OpJalr: begin
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.res_src   = 2'b10;
            w_dec.alu_src   = 2'b01;
            w_dec.imm_src   = ImmI;
            w_dec.alu       = AluAdd;
            if (w_funct3 != 3'b000) begin
               w_illegal = 1'b1;
            end
         end
         OpJal: begin
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.res_src   = 2'b10;
            w_dec.imm_src   = ImmJ;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // In TRAP without an ack the EX slot is forced to a bubble; on the ack edge decode resumes.
   assign w_trap_hold = (r_state == StTrap) && !trap_ack;
   assign w_take_trap = !flush_e && !w_trap_hold && !stall_e && valid_d && w_illegal;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next state
   always_comb begin
      w_state_d = StRun;
      if (w_take_trap || w_trap_hold) begin
         w_state_d = StTrap;
      end
   end

   // FSM outputs: next EX word and trap registers
   always_comb begin
      w_ex_d       = '0;
      w_trap_req_d = 1'b0;
      w_trap_pc_d  = r_trap_pc;
      if (flush_e || w_trap_hold) begin
         w_ex_d = '0;
      end else if (stall_e) begin
         w_ex_d = r_ex;
      end else if (valid_d && !w_illegal) begin
         w_ex_d = w_dec;
      end
      if (w_take_trap) begin
         w_trap_req_d = 1'b1;
         w_trap_pc_d  = pc_d;
      end else if (w_trap_hold) begin
         w_trap_req_d = r_trap_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex       <= '0;
         r_trap_req <= 1'b0;
         r_trap_pc  <= '0;
      end else begin
         r_ex       <= w_ex_d;
         r_trap_req <= w_trap_req_d;
         r_trap_pc  <= w_trap_pc_d;
      end
   end

   assign valid_e       = r_ex.valid;
   assign reg_write_e   = r_ex.reg_write;
   assign res_src_e     = r_ex.res_src;
   assign mem_write_e   = r_ex.mem_write;
   assign jump_e        = r_ex.jump;
   assign branch_e      = r_ex.branch;
   assign funct3_e      = r_ex.funct3;
   assign alu_control_e = ALU_CTRL_W'(r_ex.alu);
   assign alu_src_e     = r_ex.alu_src;
   assign imm_src_e     = r_ex.imm_src;
   assign rd_e          = r_ex.rd;
   assign rs1_e         = r_ex.rs1;
   assign rs2_e         = r_ex.rs2;
   assign trap_req      = r_trap_req;
   assign trap_pc       = r_trap_pc;

endmodule
